// File: rtl/alu_rs.sv
// Reservation station for the scalar ALU: buffers dispatched ops, snoops the ALU and
// load/store result buses for pending operands, and issues one ready op per cycle.
module alu_rs #(
    parameter int RS_WIDTH_BIT  = 3,
    parameter int ROB_WIDTH_BIT = 4,
    parameter int TYPE_BIT      = 5
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear_in,
    input  logic                     inst_valid,
    input  logic [TYPE_BIT-1:0]      inst_type,
    input  logic [ROB_WIDTH_BIT-1:0] inst_rob_id,
    input  logic [31:0]              inst_v1,
    input  logic [31:0]              inst_v2,
    input  logic                     inst_has_dep1,
    input  logic                     inst_has_dep2,
    input  logic [ROB_WIDTH_BIT-1:0] inst_q1,
    input  logic [ROB_WIDTH_BIT-1:0] inst_q2,
    input  logic                     alu_res_ready,
    input  logic [ROB_WIDTH_BIT-1:0] alu_res_rob_id,
    input  logic [31:0]              alu_res_value,
    input  logic                     lsb_res_ready,
    input  logic [ROB_WIDTH_BIT-1:0] lsb_res_rob_id,
    input  logic [31:0]              lsb_res_value,
    output logic                     full,
    output logic                     alu_valid,
    output logic [TYPE_BIT-1:0]      alu_type,
    output logic [31:0]              alu_r1,
    output logic [31:0]              alu_r2,
    output logic [ROB_WIDTH_BIT-1:0] alu_rob_id
);

    localparam int RS_SIZE = 1 << RS_WIDTH_BIT;

    logic [RS_SIZE-1:0]       busy;
    logic [RS_SIZE-1:0]       dep1;
    logic [RS_SIZE-1:0]       dep2;
    logic [TYPE_BIT-1:0]      e_type [RS_SIZE];
    logic [ROB_WIDTH_BIT-1:0] e_rob  [RS_SIZE];
    logic [31:0]              e_v1   [RS_SIZE];
    logic [31:0]              e_v2   [RS_SIZE];
    logic [ROB_WIDTH_BIT-1:0] e_q1   [RS_SIZE];
    logic [ROB_WIDTH_BIT-1:0] e_q2   [RS_SIZE];

    logic [RS_SIZE-1:0]       ready;
    logic [RS_WIDTH_BIT-1:0]  free_idx;
    logic [RS_WIDTH_BIT-1:0]  sel_idx;
    logic                     sel_found;

    logic [32:0]              wk1 [RS_SIZE];
    logic [32:0]              wk2 [RS_SIZE];
    logic [32:0]              disp1;
    logic [32:0]              disp2;

    // Returns {still_pending, value}; the ALU bus takes precedence on a tag tie.
    function automatic logic [32:0] snoop(input logic dep,
                                          input logic [ROB_WIDTH_BIT-1:0] q,
                                          input logic [31:0] v);
        if (dep && alu_res_ready && alu_res_rob_id == q)
            return {1'b0, alu_res_value};
        if (dep && lsb_res_ready && lsb_res_rob_id == q)
            return {1'b0, lsb_res_value};
        return {dep, v};
    endfunction

    assign full  = &busy;
    assign ready = busy & ~dep1 & ~dep2;

    always_comb begin
        free_idx  = '0;
        sel_idx   = '0;
        sel_found = |ready;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i])
                free_idx = RS_WIDTH_BIT'(i);
            if (ready[i])
                sel_idx = RS_WIDTH_BIT'(i);
        end
    end

    always_comb begin
        disp1 = snoop(inst_has_dep1, inst_q1, inst_v1);
        disp2 = snoop(inst_has_dep2, inst_q2, inst_v2);
        for (int i = 0; i < RS_SIZE; i++) begin
            wk1[i] = snoop(dep1[i], e_q1[i], e_v1[i]);
            wk2[i] = snoop(dep2[i], e_q2[i], e_v2[i]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            busy       <= '0;
            dep1       <= '0;
            dep2       <= '0;
            alu_valid  <= 1'b0;
            alu_type   <= '0;
            alu_r1     <= '0;
            alu_r2     <= '0;
            alu_rob_id <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                e_type[i] <= '0;
                e_rob[i]  <= '0;
                e_v1[i]   <= '0;
                e_v2[i]   <= '0;
                e_q1[i]   <= '0;
                e_q2[i]   <= '0;
            end
        end else if (rdy_in) begin
            if (clear_in) begin
                busy      <= '0;
                alu_valid <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i]) begin
                        {dep1[i], e_v1[i]} <= wk1[i];
                        {dep2[i], e_v2[i]} <= wk2[i];
                    end
                end
                // Selection uses start-of-cycle state, so same-cycle wakeups wait a cycle.
                if (sel_found) begin
                    alu_valid      <= 1'b1;
                    alu_type       <= e_type[sel_idx];
                    alu_r1         <= e_v1[sel_idx];
                    alu_r2         <= e_v2[sel_idx];
                    alu_rob_id     <= e_rob[sel_idx];
                    busy[sel_idx]  <= 1'b0;
                end else begin
                    alu_valid <= 1'b0;
                end
                if (inst_valid && !full) begin
                    busy[free_idx]               <= 1'b1;
                    e_type[free_idx]             <= inst_type;
                    e_rob[free_idx]              <= inst_rob_id;
                    e_q1[free_idx]               <= inst_q1;
                    e_q2[free_idx]               <= inst_q2;
                    {dep1[free_idx], e_v1[free_idx]} <= disp1;
                    {dep2[free_idx], e_v2[free_idx]} <= disp2;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: table of single-op dispatch/issue vectors plus
// hand-written sequences for wakeup, full, flush and stall behaviour.
module tb_alu_rs;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_in;
    logic        inst_valid;
    logic [4:0]  inst_type;
    logic [3:0]  inst_rob_id;
    logic [31:0] inst_v1;
    logic [31:0] inst_v2;
    logic        inst_has_dep1;
    logic        inst_has_dep2;
    logic [3:0]  inst_q1;
    logic [3:0]  inst_q2;
    logic        alu_res_ready;
    logic [3:0]  alu_res_rob_id;
    logic [31:0] alu_res_value;
    logic        lsb_res_ready;
    logic [3:0]  lsb_res_rob_id;
    logic [31:0] lsb_res_value;
    logic        full;
    logic        alu_valid;
    logic [4:0]  alu_type;
    logic [31:0] alu_r1;
    logic [31:0] alu_r2;
    logic [3:0]  alu_rob_id;

    alu_rs dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .inst_valid(inst_valid), .inst_type(inst_type), .inst_rob_id(inst_rob_id),
        .inst_v1(inst_v1), .inst_v2(inst_v2),
        .inst_has_dep1(inst_has_dep1), .inst_has_dep2(inst_has_dep2),
        .inst_q1(inst_q1), .inst_q2(inst_q2),
        .alu_res_ready(alu_res_ready), .alu_res_rob_id(alu_res_rob_id),
        .alu_res_value(alu_res_value),
        .lsb_res_ready(lsb_res_ready), .lsb_res_rob_id(lsb_res_rob_id),
        .lsb_res_value(lsb_res_value),
        .full(full), .alu_valid(alu_valid), .alu_type(alu_type),
        .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_rob_id(alu_rob_id)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [4:0]  typ;
        logic [3:0]  rob;
        logic [31:0] v1;
        logic [31:0] v2;
        logic        d1;
        logic [3:0]  q1;
        logic        d2;
        logic [3:0]  q2;
        logic [1:0]  bus;   // bit0 drives the ALU bus, bit1 the load/store bus
        logic [3:0]  btag;
        logic [31:0] aval;
        logic [31:0] lval;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t tbl [5];
    int   vectors;
    int   miscompares;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        inst_valid    = 1'b0;
        inst_has_dep1 = 1'b0;
        inst_has_dep2 = 1'b0;
        clear_in      = 1'b0;
        alu_res_ready = 1'b0;
        lsb_res_ready = 1'b0;
    endtask

    task automatic dispatch(input logic [4:0] t, input logic [3:0] rob,
                            input logic [31:0] v1, input logic [31:0] v2,
                            input logic d1, input logic [3:0] q1,
                            input logic d2, input logic [3:0] q2);
        inst_valid    = 1'b1;
        inst_type     = t;
        inst_rob_id   = rob;
        inst_v1       = v1;
        inst_v2       = v2;
        inst_has_dep1 = d1;
        inst_q1       = q1;
        inst_has_dep2 = d2;
        inst_q2       = q2;
    endtask

    task automatic chk_issue(input string nm, input logic [4:0] t, input logic [3:0] rob,
                             input logic [31:0] r1, input logic [31:0] r2);
        chk({nm, " valid"}, alu_valid, 1);
        chk({nm, " type"},  alu_type, t);
        chk({nm, " rob"},   alu_rob_id, rob);
        chk({nm, " r1"},    alu_r1, r1);
        chk({nm, " r2"},    alu_r2, r2);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        tbl[0] = '{5'b00000, 4'd3,  32'd5,        32'd7,        1'b0, 4'd0, 1'b0, 4'd0,  2'b00, 4'd0,
                   32'd0,     32'd0,      32'd5,        32'd7};
        tbl[1] = '{5'b10001, 4'd1,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 4'd0, 1'b0, 4'd0, 2'b00, 4'd0,
                   32'd0,     32'd0,      32'hFFFF_FFFF, 32'h8000_0000};
        tbl[2] = '{5'b01000, 4'd4,  32'h55,       32'd3,        1'b1, 4'd9, 1'b0, 4'd0,  2'b10, 4'd9,
                   32'd0,     32'hDEAD,   32'hDEAD,     32'd3};
        tbl[3] = '{5'b00111, 4'd14, 32'h100,      32'h77,       1'b0, 4'd0, 1'b1, 4'd11, 2'b01, 4'd11,
                   32'hCAFE,  32'd0,      32'h100,      32'hCAFE};
        tbl[4] = '{5'b01101, 4'd15, 32'h1,        32'h2,        1'b1, 4'd8, 1'b1, 4'd8,  2'b11, 4'd8,
                   32'h111,   32'h222,    32'h111,      32'h111};

        idle();
        inst_type = '0; inst_rob_id = '0; inst_v1 = '0; inst_v2 = '0;
        inst_q1 = '0; inst_q2 = '0;
        alu_res_rob_id = '0; alu_res_value = '0;
        lsb_res_rob_id = '0; lsb_res_value = '0;
        rdy_in = 1'b1;
        rst_in = 1'b0;
        step();
        step();
        chk("reset valid", alu_valid, 0);
        chk("reset full",  full, 0);
        chk("reset type",  alu_type, 0);
        chk("reset r1",    alu_r1, 0);
        chk("reset r2",    alu_r2, 0);
        chk("reset rob",   alu_rob_id, 0);
        rst_in = 1'b1;
        step();

        // Single-op vectors, including dispatch-time bypass from either bus.
        for (int i = 0; i < 5; i++) begin
            dispatch(tbl[i].typ, tbl[i].rob, tbl[i].v1, tbl[i].v2,
                     tbl[i].d1, tbl[i].q1, tbl[i].d2, tbl[i].q2);
            alu_res_ready  = tbl[i].bus[0];
            alu_res_rob_id = tbl[i].btag;
            alu_res_value  = tbl[i].aval;
            lsb_res_ready  = tbl[i].bus[1];
            lsb_res_rob_id = tbl[i].btag;
            lsb_res_value  = tbl[i].lval;
            step();
            idle();
            chk($sformatf("vec%0d pre-issue valid", i), alu_valid, 0);
            step();
            chk_issue($sformatf("vec%0d", i), tbl[i].typ, tbl[i].rob, tbl[i].e1, tbl[i].e2);
            step();
            chk($sformatf("vec%0d drained", i), alu_valid, 0);
        end

        // SUB waiting on rob 6, woken by the ALU bus.
        dispatch(5'b01000, 4'd2, 32'h20, 32'h0, 1'b0, 4'd0, 1'b1, 4'd6);
        step();
        idle();
        step();
        chk("wake pending valid", alu_valid, 0);
        step();
        chk("wake pending valid2", alu_valid, 0);
        alu_res_ready  = 1'b1;
        alu_res_rob_id = 4'd6;
        alu_res_value  = 32'h10;
        step();
        idle();
        chk("wake edge valid", alu_valid, 0);
        step();
        chk_issue("wake issue", 5'b01000, 4'd2, 32'h20, 32'h10);
        step();
        chk("wake drained", alu_valid, 0);

        // Fill all 8 entries behind rob 15, then a ninth (ready) dispatch that must be dropped.
        for (int i = 0; i < 8; i++) begin
            dispatch(5'b00000, 4'(i), 32'h0, 32'(i), 1'b1, 4'd15, 1'b0, 4'd0);
            step();
        end
        idle();
        chk("full after 8", full, 1);
        dispatch(5'b00001, 4'd12, 32'h9, 32'h9, 1'b0, 4'd0, 1'b0, 4'd0);
        step();
        idle();
        chk("full ninth", full, 1);
        step();
        chk("ninth dropped", alu_valid, 0);
        alu_res_ready  = 1'b1;
        alu_res_rob_id = 4'd15;
        alu_res_value  = 32'h1234;
        step();
        idle();
        chk("bcast edge valid", alu_valid, 0);
        chk("bcast edge full", full, 1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk_issue($sformatf("drain%0d", i), 5'b00000, 4'(i), 32'h1234, 32'(i));
            if (i == 0)
                chk("full after first issue", full, 0);
        end
        step();
        chk("drain done", alu_valid, 0);

        // Flush with a ready entry eligible and a simultaneous dispatch.
        for (int i = 0; i < 3; i++) begin
            dispatch(5'b00000, 4'(i), 32'h0, 32'h0, 1'b1, 4'd7, 1'b0, 4'd0);
            step();
        end
        dispatch(5'b00000, 4'd3, 32'h77, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0);
        step();
        dispatch(5'b00000, 4'd5, 32'h99, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0);
        clear_in = 1'b1;
        step();
        idle();
        chk("clear valid", alu_valid, 0);
        chk("clear full", full, 0);
        step();
        chk("clear dispatch lost", alu_valid, 0);
        alu_res_ready  = 1'b1;
        alu_res_rob_id = 4'd7;
        alu_res_value  = 32'h5;
        step();
        idle();
        step();
        chk("clear no wake", alu_valid, 0);
        step();
        chk("clear no wake2", alu_valid, 0);

        // Stall: rdy_in low freezes the outputs and drops the dispatch in that window.
        dispatch(5'b00010, 4'd4, 32'hAA, 32'hBB, 1'b0, 4'd0, 1'b0, 4'd0);
        step();
        dispatch(5'b00011, 4'd9, 32'h11, 32'h22, 1'b0, 4'd0, 1'b0, 4'd0);
        step();
        chk_issue("pre-stall", 5'b00010, 4'd4, 32'hAA, 32'hBB);
        rdy_in = 1'b0;
        dispatch(5'b00100, 4'd10, 32'h33, 32'h44, 1'b0, 4'd0, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            idle();
            chk_issue($sformatf("stall%0d", i), 5'b00010, 4'd4, 32'hAA, 32'hBB);
        end
        rdy_in = 1'b1;
        step();
        chk_issue("post-stall", 5'b00011, 4'd9, 32'h11, 32'h22);
        step();
        chk("stall dispatch lost", alu_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station for the scalar ALU in the out-of-order core. Accepts decoded integer and branch-compare instructions from dispatch, waits for pending source operands by snooping the ALU and load/store result buses, and issues at most one ready instruction per cycle to the ALU. Sits between the decoder/ROB dispatch stage and the ALU input port.

## Interface
- RS_WIDTH_BIT, 3: log2 of entry count (8 entries)
- ROB_WIDTH_BIT, 4: ROB tag width
- TYPE_BIT, 5: op-type width; bit 4 selects branch compare, bit 3 selects sub/sra, bits 2:0 select funct3
- clk_in  input  1  system clock
- rst_in  input  1  reset, synchronous, active-low
- rdy_in  input  1  global ready; low freezes the block
- clear_in  input  1  misprediction flush
- inst_valid  input  1  dispatch request
- inst_type  input  TYPE_BIT  op type
- inst_rob_id  input  ROB_WIDTH_BIT  destination ROB tag
- inst_v1, inst_v2  input  32 each  operand values (meaningful when no dependency)
- inst_has_dep1, inst_has_dep2  input  1 each  operand still pending
- inst_q1, inst_q2  input  ROB_WIDTH_BIT each  producer tag of pending operand
- alu_res_ready  input  1  ALU result bus valid
- alu_res_rob_id  input  ROB_WIDTH_BIT  ALU result tag
- alu_res_value  input  32  ALU result
- lsb_res_ready, lsb_res_rob_id, lsb_res_value  input  1/ROB_WIDTH_BIT/32  load/store result bus
- full  output  1  all entries busy (combinational)
- alu_valid  output  1  issue strobe to ALU (registered)
- alu_type  output  TYPE_BIT  issued op type
- alu_r1, alu_r2  output  32 each  issued operands
- alu_rob_id  output  ROB_WIDTH_BIT  issued tag

## Operation
- Entry fields: busy, type, rob_id, v1, has_dep1, q1, v2, has_dep2, q2.
- Priority per cycle when rdy_in high: reset > clear_in > normal update.
- clear_in: all busy bits cleared, alu_valid <= 0; dispatch in the same cycle discarded.
- Dispatch: inst_valid && !full writes the lowest-index non-busy entry. inst_valid while full is ignored (no state change).
- Dispatch bypass: if a pending operand's q matches a valid result bus in the same cycle, the entry stores the bus value with has_dep cleared.
- Wakeup: every busy entry with has_depX set and qX equal to a valid bus tag captures the value and clears has_depX. ALU bus wins if both buses carry the same tag (protocol forbids this; deterministic only).
- Select: lowest-index entry that is busy with has_dep1 == has_dep2 == 0 according to registered state at the start of the cycle. Same-cycle wakeups become eligible next cycle.
- Issue: selected entry's fields are registered onto alu_* with alu_valid <= 1, and its busy bit cleared on the same edge. With no eligible entry, alu_valid <= 0 and the other alu_* hold.
- full = all busy bits set, from registered state; a same-cycle issue does not deassert it.
- Freed entry is reusable by dispatch on the following cycle.
- rdy_in low: no state or output changes; buses and dispatch in that cycle are lost (producers hold while rdy_in is low).

## Timing
- Reset (rst_in low at edge): all busy = 0; alu_valid, alu_type, alu_r1, alu_r2, alu_rob_id = 0; full = 0 after the edge.
- Dispatch with both operands ready at edge N: eligible in cycle N+1; alu_valid high after edge N+1; ALU result after edge N+2.
- Pending operand woken at edge N: issue no earlier than edge N+1.
- Throughput: one issue per cycle; 8 back-to-back ready dispatches drain in 8 consecutive alu_valid cycles.
- clear_in at edge N: alu_valid low after edge N, even if an issue was eligible.

## Test plan
- Reset then dispatch ADD (type 5'b00000, v1=5, v2=7, rob 3, no deps) -> one cycle later alu_valid=1, alu_r1=5, alu_r2=7, alu_rob_id=3, alu_type=0; next cycle alu_valid=0.
- Dispatch SUB (rob 2) with has_dep2=1, q2=6; later alu_res_ready with rob 6, value 0x10 -> no issue before wakeup edge; issue on the following edge with alu_r2=0x10, alu_type=5'b01000.
- Dispatch with has_dep1=1, q1=9 while lsb_res_ready carries rob 9, value 0xDEAD -> entry stored ready; issues next cycle with alu_r1=0xDEAD.
- Fill 8 entries all dependent on rob 15 -> full=1; ninth dispatch ignored; broadcast rob 15 -> issues in index order 0..7 on 8 consecutive cycles; full drops after the first issue.
- 4 busy entries, assert clear_in with simultaneous inst_valid -> all entries empty, alu_valid=0, later broadcasts cause no issue.
- rdy_in low for 3 cycles with a ready entry present -> alu_* frozen at prior values; issue occurs on the first edge with rdy_in high.
